// File: rtl/cog_point_divider.sv
// Centre-of-gravity point divider: queues figure events, divides sum(I^2*x) by sum(I^2)
// with a restoring radix-2 divider and emits sub-pixel centres in push order.
module cog_point_divider #(
    parameter int FRAC_BITS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 1280
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    input  logic [29:0]            i_sum_of_I_mult_coord,
    input  logic [22:0]            i_sum_of_I,
    input  logic [10:0]            i_start_point,
    input  logic                   i_point_is_valid,
    input  logic                   i_new_frame,
    input  logic                   i_end_of_line,
    input  logic                   i_end_of_frame,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_point_present,
    output logic [11+FRAC_BITS-1:0] o_point,
    output logic                   o_div_by_zero,
    output logic                   o_new_frame,
    output logic                   o_end_of_line,
    output logic                   o_end_of_frame,
    output logic                   o_overflow
);

    localparam int DIV_CYCLES = 30 + FRAC_BITS;
    localparam int QW         = 30 + FRAC_BITS;
    localparam int PW         = 11 + FRAC_BITS;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LP_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [QW:0]   LP_ONE  = (QW+1)'(2**FRAC_BITS);
    localparam logic [QW:0]   LP_MAX  = (QW+1)'(((WIDTH - 1) << FRAC_BITS) + (2**FRAC_BITS - 1));

    typedef struct packed {
        logic        pt;
        logic [29:0] mult;
        logic [22:0] sumi;
        logic [10:0] start;
        logic        nf;
        logic        eol;
        logic        eof;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ADJUST, S_OUTPUT} state_t;

    entry_t        r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [QW-1:0] r_dq;
    logic [23:0]   r_rem;
    logic [22:0]   r_div;
    logic [10:0]   r_start;

    entry_t      w_in;
    entry_t      w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_event;
    logic        w_pop;
    logic        w_push;
    logic [24:0] w_shift;
    logic        w_ge;
    logic [23:0] w_diff;
    logic [QW:0] w_adj;

    assign w_in    = {i_point_is_valid, i_sum_of_I_mult_coord, i_sum_of_I, i_start_point,
                      i_new_frame, i_end_of_line, i_end_of_frame};
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_event = i_point_is_valid | i_new_frame | i_end_of_line | i_end_of_frame;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_push  = w_event && (!w_full || w_pop);

    assign w_shift = {r_rem, r_dq[QW-1]};
    assign w_ge    = (w_shift >= {2'b00, r_div});
    assign w_diff  = w_shift[23:0] - {1'b0, r_div};
    assign w_adj   = {{(QW+1-PW){1'b0}}, r_start, {FRAC_BITS{1'b0}}} + {1'b0, r_dq} - LP_ONE;

    always_ff @(posedge i_sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_in;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_event && !w_push) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_dq            <= '0;
            r_rem           <= '0;
            r_div           <= '0;
            r_start         <= '0;
            o_valid         <= 1'b0;
            o_point_present <= 1'b0;
            o_point         <= '0;
            o_div_by_zero   <= 1'b0;
            o_new_frame     <= 1'b0;
            o_end_of_line   <= 1'b0;
            o_end_of_frame  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        o_point_present <= w_head.pt;
                        o_new_frame     <= w_head.nf;
                        o_end_of_line   <= w_head.eol;
                        o_end_of_frame  <= w_head.eof;
                        r_start         <= w_head.start;
                        if (w_head.pt && (w_head.sumi != '0)) begin
                            r_dq          <= {w_head.mult, {FRAC_BITS{1'b0}}};
                            r_div         <= w_head.sumi;
                            r_rem         <= '0;
                            r_cnt         <= '0;
                            o_div_by_zero <= 1'b0;
                            r_state       <= S_DIVIDE;
                        end else begin
                            // Zero divisor reports the start pixel itself.
                            o_point       <= w_head.pt ? {w_head.start, {FRAC_BITS{1'b0}}} : '0;
                            o_div_by_zero <= w_head.pt;
                            o_valid       <= 1'b1;
                            r_state       <= S_OUTPUT;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_dq  <= {r_dq[QW-2:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_shift[23:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LP_LAST) begin
                        r_state <= S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    o_point <= (w_adj > LP_MAX) ? LP_MAX[PW-1:0] : w_adj[PW-1:0];
                    o_valid <= 1'b1;
                    r_state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cog_point_divider.sv
// Bench for cog_point_divider: directed latency/ordering/overflow/reset cases plus
// randomized bursts checked against an arithmetic reference model.
module tb_cog_point_divider;

    localparam int F  = 4;
    localparam int PW = 11 + F;
    localparam longint CLAMP = ((1280 - 1) << F) + (2**F - 1);

    logic          clk = 1'b0;
    logic          i_sys_rst = 1'b1;
    logic [29:0]   i_sum_of_I_mult_coord = '0;
    logic [22:0]   i_sum_of_I = '0;
    logic [10:0]   i_start_point = '0;
    logic          i_point_is_valid = 1'b0;
    logic          i_new_frame = 1'b0;
    logic          i_end_of_line = 1'b0;
    logic          i_end_of_frame = 1'b0;
    logic          i_ready;
    logic          o_valid;
    logic          o_point_present;
    logic [PW-1:0] o_point;
    logic          o_div_by_zero;
    logic          o_new_frame;
    logic          o_end_of_line;
    logic          o_end_of_frame;
    logic          o_overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastPushCyc = 0;
    int beatCount = 0;
    logic readyLevel = 1'b1;
    logic randReady = 1'b0;
    logic [PW+4:0] expQ [$];

    cog_point_divider #(.FRAC_BITS(F), .FIFO_DEPTH(4), .WIDTH(1280)) dut (
        .i_sys_clk(clk), .i_sys_rst(i_sys_rst),
        .i_sum_of_I_mult_coord(i_sum_of_I_mult_coord), .i_sum_of_I(i_sum_of_I),
        .i_start_point(i_start_point), .i_point_is_valid(i_point_is_valid),
        .i_new_frame(i_new_frame), .i_end_of_line(i_end_of_line), .i_end_of_frame(i_end_of_frame),
        .o_valid(o_valid), .i_ready(i_ready), .o_point_present(o_point_present),
        .o_point(o_point), .o_div_by_zero(o_div_by_zero), .o_new_frame(o_new_frame),
        .o_end_of_line(o_end_of_line), .o_end_of_frame(o_end_of_frame), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        i_ready = randReady ? ($urandom_range(0, 3) != 0) : readyLevel;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beat straight from the centre formula, clamp included.
    function automatic logic [PW+4:0] expectBeat(input logic pt, input logic [29:0] mult,
            input logic [22:0] sumi, input logic [10:0] start,
            input logic nf, input logic eol, input logic eof);
        longint p;
        logic [PW-1:0] pv;
        if (!pt) p = 0;
        else if (sumi == 0) p = longint'(start) * 16;
        else begin
            p = longint'(start) * 16 + (longint'(mult) * 16) / longint'(sumi) - 16;
            if (p > CLAMP) p = CLAMP;
        end
        pv = PW'(p);
        return {pt, pv, pt && (sumi == 0), nf, eol, eof};
    endfunction

    always @(negedge clk) begin
        if (!i_sys_rst && o_valid && i_ready) begin
            beatCount = beatCount + 1;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 64'd1, 64'd0);
            end else begin
                checkOutput("beat", {o_point_present, o_point, o_div_by_zero, o_new_frame,
                                     o_end_of_line, o_end_of_frame}, expQ.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic pt, input logic [29:0] mult, input logic [22:0] sumi,
            input logic [10:0] start, input logic nf, input logic eol, input logic eof,
            input logic keep);
        i_point_is_valid      = pt;
        i_sum_of_I_mult_coord = mult;
        i_sum_of_I            = sumi;
        i_start_point         = start;
        i_new_frame           = nf;
        i_end_of_line         = eol;
        i_end_of_frame        = eof;
        lastPushCyc           = cyc;
        if (keep && (pt || nf || eol || eof)) expQ.push_back(expectBeat(pt, mult, sumi, start, nf, eol, eof));
        @(posedge clk);
        #1;
        i_point_is_valid = 1'b0;
        i_new_frame      = 1'b0;
        i_end_of_line    = 1'b0;
        i_end_of_frame   = 1'b0;
    endtask

    task automatic measureLatency(input string tag, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 200);
        checkOutput(tag, 64'(cyc - lastPushCyc), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((expQ.size() != 0 || o_valid) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_left", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b0;
        logic [22:0] s;
        logic [29:0] m;
        longint lm;
        int kind;
        idle(3);
        @(negedge clk);
        checkOutput("reset_valid_ovf", {o_valid, o_overflow}, 2'b00);
        checkOutput("reset_beat", {o_point_present, o_point, o_div_by_zero, o_new_frame,
                                   o_end_of_line, o_end_of_frame}, '0);
        @(posedge clk);
        #1;
        i_sys_rst = 1'b0;
        idle(2);

        $display("[TB] point only / fraction / zero divisor");
        applyStimulus(1, 30'd6000, 23'd3000, 11'd100, 0, 0, 0, 1);
        measureLatency("lat_point", 37);
        waitDrain(100);
        applyStimulus(1, 30'd5, 23'd2, 11'd0, 0, 0, 0, 1);
        measureLatency("lat_fraction", 37);
        waitDrain(100);
        applyStimulus(1, 30'd77, 23'd0, 11'd37, 0, 0, 0, 1);
        measureLatency("lat_zero_div", 2);
        waitDrain(100);
        applyStimulus(0, 30'd0, 23'd0, 11'd0, 0, 1, 0, 1);
        measureLatency("lat_marker", 2);
        waitDrain(100);

        $display("[TB] ordering");
        b0 = beatCount;
        applyStimulus(1, 30'd9000, 23'd1000, 11'd500, 0, 0, 0, 1);
        applyStimulus(0, 30'd0, 23'd0, 11'd0, 0, 1, 0, 1);
        idle(3);
        applyStimulus(0, 30'd0, 23'd0, 11'd0, 1, 0, 1, 1);
        waitDrain(300);
        checkOutput("order_beats", 64'(beatCount - b0), 64'd3);

        $display("[TB] overflow with back-pressure");
        readyLevel = 1'b0;
        idle(1);
        b0 = beatCount;
        for (int i = 0; i < 5; i++) applyStimulus(1, 30'(1000 + 100 * i), 23'd100, 11'(10 * i), 0, 0, 0, 1);
        checkOutput("ovf_before", 64'(o_overflow), 64'd0);
        applyStimulus(1, 30'd4321, 23'd123, 11'd900, 0, 0, 0, 0);
        checkOutput("ovf_after", 64'(o_overflow), 64'd1);
        idle(60);
        readyLevel = 1'b1;
        waitDrain(1000);
        checkOutput("ovf_beats", 64'(beatCount - b0), 64'd5);
        checkOutput("ovf_sticky", 64'(o_overflow), 64'd1);
        i_sys_rst = 1'b1;
        idle(1);
        i_sys_rst = 1'b0;
        checkOutput("ovf_cleared", 64'(o_overflow), 64'd0);

        $display("[TB] reset mid-divide");
        idle(2);
        b0 = beatCount;
        applyStimulus(1, 30'd6000, 23'd3000, 11'd100, 0, 0, 0, 1);
        applyStimulus(0, 30'd0, 23'd0, 11'd0, 0, 1, 0, 1);
        idle(9);
        i_sys_rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;
        i_sys_rst = 1'b0;
        idle(80);
        checkOutput("rst_no_stale", {32'(beatCount - b0), 31'd0, o_valid}, 64'd0);

        $display("[TB] randomized bursts");
        randReady = 1'b1;
        for (int burst = 0; burst < 40; burst++) begin
            for (int e = 0; e < $urandom_range(1, 4); e++) begin
                kind = $urandom_range(0, 9);
                s = ($urandom_range(0, 1) != 0) ? 23'($urandom_range(1, 1000)) : 23'($urandom_range(1, 23'h7FFFFF));
                if ($urandom_range(0, 3) == 0) lm = $urandom_range(30'h3FFFFFFF, 32'(s));
                else lm = longint'(s) * $urandom_range(1, 40) + $urandom_range(0, 32'(s) - 1);
                if (lm > 64'h3FFFFFFF) lm = 64'h3FFFFFFF;
                m = 30'(lm);
                if (kind <= 5)
                    applyStimulus(1, m, s, 11'($urandom_range(0, 1279)), ($urandom_range(0, 3) == 0),
                                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
                else if (kind == 6)
                    applyStimulus(1, m, 23'd0, 11'($urandom_range(0, 1279)), 0, 0, 0, 1);
                else
                    applyStimulus(0, 30'd0, 23'd0, 11'd0, (kind == 7), (kind != 7), (kind == 9), 1);
                idle($urandom_range(0, 3));
            end
            waitDrain(2000);
        end
        checkOutput("rand_no_overflow", 64'(o_overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
